micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 169 ++++++++++++++++
 tb/tb_micro_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: three-phase (FETCH/EXEC/NEXT) microprogram sequencer with a
// 512 x 40 writable control store, JAMN/JAMZ/JMPC branching and self-loop halt.
// Optional feature: define SINGLE_STEP_EN to add the step input and a PAUSE
// state between microinstructions.
module micro_sequencer #(
   parameter logic [8:0]  START_ADDR        = 9'h000,
   parameter int unsigned HALT_ON_SELF_LOOP = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        n_flag,
   input  logic        z_flag,
   input  logic [7:0]  mbr,
   input  logic        cs_we,
   input  logic [8:0]  cs_addr,
   input  logic [39:0] cs_data,
`ifdef SINGLE_STEP_EN
   input  logic        step,
`endif
   output logic [27:0] mir,
   output logic [8:0]  mpc,
   output logic [1:0]  phase,
   output logic        halted
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StNext,
`ifdef SINGLE_STEP_EN
      StPause,
`endif
      StHalt
   } state_e;

   state_e      state_q, state_d;
   logic [8:0]  mpc_q, mpc_d;
   logic [27:0] mir_q, mir_d;
   logic        jmpc_q, jmpc_d;
   logic        jamn_q, jamn_d;
   logic        jamz_q, jamz_d;
   logic [8:0]  next_q, next_d;
   logic        halted_q;

   logic [39:0] cs_mem [512];
   logic [39:0] cs_word;
   logic        cs_wr_ok;
   logic [8:0]  branch_addr;
   logic        self_loop;

   assign cs_word  = cs_mem[mpc_q];
   assign cs_wr_ok = cs_we && ((state_q == StIdle) || (state_q == StHalt));

   // Control store: written only while stopped, never cleared by reset.
   always_ff @(posedge clock) begin
      if (cs_wr_ok) begin
         cs_mem[cs_addr] <= cs_data;
      end
   end

   // Branch target from the latched fields and the live datapath flags/opcode.
   always_comb begin
      branch_addr = next_q;
      if (jmpc_q) begin
         branch_addr[7:0] = next_q[7:0] | mbr;
      end
      if ((jamn_q && n_flag) || (jamz_q && z_flag)) begin
         branch_addr[8] = 1'b1;
      end
   end

   assign self_loop = (HALT_ON_SELF_LOOP != 0) && !jmpc_q && !jamn_q && !jamz_q &&
                      (next_q == mpc_q);

   // Next-state, next mpc and mir latching.
   always_comb begin
      state_d = state_q;
      mpc_d   = mpc_q;
      mir_d   = mir_q;
      jmpc_d  = jmpc_q;
      jamn_d  = jamn_q;
      jamz_d  = jamz_q;
      next_d  = next_q;
      case (state_q)
         StIdle, StHalt: begin
            if (start) begin
               state_d = StFetch;
               mpc_d   = START_ADDR;
            end
         end
         StFetch: begin
            mir_d   = cs_word[27:0];
            jmpc_d  = cs_word[39];
            jamn_d  = cs_word[38];
            jamz_d  = cs_word[37];
            next_d  = cs_word[36:28];
            state_d = StExec;
         end
         StExec: begin
            state_d = StNext;
         end
         StNext: begin
            mpc_d = branch_addr;
            if (self_loop) begin
               state_d = StHalt;
               mir_d   = 28'd0;
            end else begin
`ifdef SINGLE_STEP_EN
               state_d = StPause;
`else
               state_d = StFetch;
`endif
            end
         end
`ifdef SINGLE_STEP_EN
         StPause: begin
            if (step) begin
               state_d = StFetch;
            end
         end
`endif
         default: begin
            state_d = StIdle;
            mir_d   = 28'd0;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         mpc_q    <= 9'h000;
         mir_q    <= 28'd0;
         jmpc_q   <= 1'b0;
         jamn_q   <= 1'b0;
         jamz_q   <= 1'b0;
         next_q   <= 9'h000;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mpc_q    <= mpc_d;
         mir_q    <= mir_d;
         jmpc_q   <= jmpc_d;
         jamn_q   <= jamn_d;
         jamz_q   <= jamz_d;
         next_q   <= next_d;
         halted_q <= (state_d == StHalt);
      end
   end

   // Phase code decoded from the registered state.
   always_comb begin
      phase = 2'd0;
      case (state_q)
         StFetch: phase = 2'd1;
         StExec:  phase = 2'd2;
         StNext:  phase = 2'd3;
         default: phase = 2'd0;
      endcase
   end

   assign mir    = mir_q;
   assign mpc    = mpc_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: randomized self-checking bench for micro_sequencer.
// Honours SINGLE_STEP_EN (connects step and expects a PAUSE after each NEXT).
module tb_micro_sequencer;

   localparam logic [8:0] START = 9'h000;

   logic        clock   = 1'b0;
   logic        reset   = 1'b0;
   logic        start   = 1'b0;
   logic        n_flag  = 1'b0;
   logic        z_flag  = 1'b0;
   logic [7:0]  mbr     = 8'h00;
   logic        cs_we   = 1'b0;
   logic [8:0]  cs_addr = 9'h000;
   logic [39:0] cs_data = 40'h0;
`ifdef SINGLE_STEP_EN
   logic        step    = 1'b0;
`endif
   logic [27:0] mir;
   logic [8:0]  mpc;
   logic [1:0]  phase;
   logic        halted;

   int total = 0;
   int bad   = 0;
   logic [39:0] model [512];
   bit rnd_flags = 1'b0;

   always #5 clock = ~clock;

   micro_sequencer #(
      .START_ADDR        (START),
      .HALT_ON_SELF_LOOP (1)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .n_flag  (n_flag),
      .z_flag  (z_flag),
      .mbr     (mbr),
      .cs_we   (cs_we),
      .cs_addr (cs_addr),
      .cs_data (cs_data),
`ifdef SINGLE_STEP_EN
      .step    (step),
`endif
      .mir     (mir),
      .mpc     (mpc),
      .phase   (phase),
      .halted  (halted)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [39:0] rand_word(input logic [8:0] a);
      logic [39:0] w;
      w = {3'($urandom), 9'($urandom), 28'($urandom)};
      if ($urandom_range(0, 5) == 0) w[39:28] = {3'b000, a};
      return w;
   endfunction

   task automatic cs_write(input logic [8:0] a, input logic [39:0] d);
      cs_we   = 1'b1;
      cs_addr = a;
      cs_data = d;
      tick;
      cs_we   = 1'b0;
      model[a] = d;
   endtask

   // Start from IDLE/HALT, optionally with a simultaneous store write.
   task automatic start_run(input bit wr, input logic [8:0] a, input logic [39:0] d);
      start = 1'b1;
      if (wr) begin
         cs_we   = 1'b1;
         cs_addr = a;
         cs_data = d;
      end
      tick;
      start = 1'b0;
      cs_we = 1'b0;
      if (wr) model[a] = d;
   endtask

   // Random writes and starts while running; all of them must be ignored.
   task automatic noise;
      if ($urandom_range(0, 3) == 0) begin
         cs_we   = 1'b1;
         cs_addr = 9'($urandom);
         cs_data = {8'($urandom), $urandom};
      end else begin
         cs_we = 1'b0;
      end
      start = 1'($urandom);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      #1;
      check_val("rst_phase", 64'(phase), 64'd0);
      check_val("rst_mpc", 64'(mpc), 64'd0);
      check_val("rst_mir", 64'(mir), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Runs one microinstruction from its FETCH cycle; reports halt and target.
   task automatic exec_one(input logic [8:0] pc, output bit h, output logic [8:0] nxt);
      logic [39:0] w;
      int na;
      w = model[pc];
      check_val("fetch_phase", 64'(phase), 64'd1);
      check_val("fetch_mpc", 64'(mpc), 64'(pc));
      check_val("fetch_halted", 64'(halted), 64'd0);
      noise;
      tick;
      check_val("exec_phase", 64'(phase), 64'd2);
      check_val("exec_mir", 64'(mir), 64'(w[27:0]));
      check_val("exec_mpc", 64'(mpc), 64'(pc));
      noise;
      tick;
      check_val("next_phase", 64'(phase), 64'd3);
      check_val("next_mir", 64'(mir), 64'(w[27:0]));
      if (rnd_flags) begin
         n_flag = 1'($urandom);
         z_flag = 1'($urandom);
         mbr    = 8'($urandom);
      end
      noise;
      na = int'(w[36:28]);
      if (w[39]) na = (na & 'h100) | ((na & 'hFF) | int'(mbr));
      if ((w[38] && n_flag) || (w[37] && z_flag)) na = na | 'h100;
      h   = (w[39:37] == 3'b000) && (w[36:28] == pc);
      nxt = 9'(na);
      tick;
      start = 1'b0;
      cs_we = 1'b0;
      if (h) begin
         check_val("halt_halted", 64'(halted), 64'd1);
         check_val("halt_phase", 64'(phase), 64'd0);
         check_val("halt_mir", 64'(mir), 64'd0);
         check_val("halt_mpc", 64'(mpc), 64'(nxt));
      end else begin
`ifdef SINGLE_STEP_EN
         check_val("pause_phase", 64'(phase), 64'd0);
         check_val("pause_halted", 64'(halted), 64'd0);
         check_val("pause_mir", 64'(mir), 64'(w[27:0]));
         check_val("pause_mpc", 64'(mpc), 64'(nxt));
         repeat ($urandom_range(0, 2)) begin
            tick;
            check_val("pause_hold_phase", 64'(phase), 64'd0);
            check_val("pause_hold_mpc", 64'(mpc), 64'(nxt));
         end
         step = 1'b1;
         tick;
         step = 1'b0;
`endif
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] pc, nx, a;
      bit h, running, wr;

      #1 reset = 1'b1;
      #2;
      check_val("reset_phase", 64'(phase), 64'd0);
      check_val("reset_mpc", 64'(mpc), 64'd0);
      check_val("reset_mir", 64'(mir), 64'd0);
      check_val("reset_halted", 64'(halted), 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;

      for (int i = 0; i < 512; i++) cs_write(9'(i), rand_word(9'(i)));
      check_val("idle_hold_phase", 64'(phase), 64'd0);
      check_val("idle_hold_mpc", 64'(mpc), 64'd0);

      // Two-word program ending in a self-loop halt.
      cs_write(9'h000, {3'b000, 9'h001, 28'h0C4D0F1});
      cs_write(9'h001, {3'b000, 9'h001, 28'h0000001});
      start_run(1'b0, 9'h0, 40'h0);
      exec_one(9'h000, h, nx);
      check_val("prog_mpc1", 64'(mpc), 64'h001);
      exec_one(9'h001, h, nx);
      check_val("prog_halted", 64'(halted), 64'd1);
      tick;
      check_val("halt_hold", 64'(halted), 64'd1);

      // JAMZ with z set and clear.
      cs_write(9'h000, {3'b001, 9'h010, 28'h1234567});
      z_flag = 1'b1;
      start_run(1'b0, 9'h0, 40'h0);
      exec_one(9'h000, h, nx);
      check_val("jamz_set", 64'(mpc), 64'h110);
      do_reset;
      z_flag = 1'b0;
      start_run(1'b0, 9'h0, 40'h0);
      exec_one(9'h000, h, nx);
      check_val("jamz_clr", 64'(mpc), 64'h010);
      do_reset;

      // JMPC dispatch on the opcode byte.
      cs_write(9'h000, {3'b100, 9'h100, 28'h0ABCDEF});
      mbr = 8'h36;
      start_run(1'b0, 9'h0, 40'h0);
      exec_one(9'h000, h, nx);
      check_val("jmpc", 64'(mpc), 64'h136);
      do_reset;

      // Asynchronous reset during EXEC of mpc=5; store survives.
      cs_write(9'h000, {3'b000, 9'h005, 28'hAAAAAAA});
      cs_write(9'h005, {3'b000, 9'h006, 28'h5555555});
      start_run(1'b0, 9'h0, 40'h0);
      exec_one(9'h000, h, nx);
      tick;
      check_val("pre_rst_mir", 64'(mir), 64'h5555555);
      #2 reset = 1'b1;
      #1;
      check_val("async_mir", 64'(mir), 64'd0);
      check_val("async_mpc", 64'(mpc), 64'd0);
      check_val("async_phase", 64'(phase), 64'd0);
      check_val("async_halted", 64'(halted), 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      start_run(1'b0, 9'h0, 40'h0);
      exec_one(9'h000, h, nx);
      exec_one(9'h005, h, nx);
      do_reset;

      // Write during EXEC is ignored; write in HALT lands.
      cs_write(9'h000, {3'b000, 9'h000, 28'h0ABCDEF});
      start_run(1'b0, 9'h0, 40'h0);
      tick;
      cs_we   = 1'b1;
      cs_addr = 9'h000;
      cs_data = {3'b000, 9'h000, 28'h0FEDCBA};
      tick;
      cs_we = 1'b0;
      tick;
      check_val("exec_wr_halt", 64'(halted), 64'd1);
      start_run(1'b0, 9'h0, 40'h0);
      exec_one(9'h000, h, nx);
      cs_write(9'h000, {3'b000, 9'h000, 28'h0FEDCBA});
      start_run(1'b0, 9'h0, 40'h0);
      exec_one(9'h000, h, nx);
      // Write and start on the same edge: first fetch sees the new word.
      start_run(1'b1, START, {3'b000, START, 28'h0777777});
      exec_one(START, h, nx);

      // Randomized programs and flags.
      rnd_flags = 1'b1;
      running   = 1'b0;
      pc        = START;
      for (int i = 0; i < 400; i++) begin
         if (!running) begin
            if ($urandom_range(0, 2) == 0) begin
               a = 9'($urandom);
               cs_write(a, rand_word(a));
            end
            wr = ($urandom_range(0, 3) == 0);
            start_run(wr, START, rand_word(START));
            pc      = START;
            running = 1'b1;
         end
         exec_one(pc, h, nx);
         pc      = nx;
         running = !h;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
